conv_tile_sched: RTL and testbench

//  Tile scheduler for the conv datapath: walks an IMG_H x IMG_W feature map in raster tile order,

---
 rtl/conv_tile_sched_pkg.sv | 15 +
 rtl/conv_tile_sched_coord.sv | 32 +++
 rtl/conv_tile_sched.sv | 120 ++++++++++++
 tb/tb_conv_tile_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_tile_sched_pkg.sv
// conv_tile_sched_pkg: FSM state encoding and elaboration helpers shared by the tile scheduler
package conv_tile_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CLEAR,
    S_RUN,
    S_EMIT,
    S_ADV,
    S_DONE
  } state_t;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/conv_tile_sched_coord.sv
// conv_tile_sched_coord: raster tile counter (tx fastest) with clear, advance and last-tile flag
module conv_tile_sched_coord #(
  parameter int TILES_Y = 2,
  parameter int TILES_X = 2,
  parameter int CW      = 3
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [CW-1:0] o_ty,
  output logic [CW-1:0] o_tx,
  output logic          o_last
);
  logic [CW-1:0] r_ty;
  logic [CW-1:0] r_tx;
  logic          w_row_end;
  assign w_row_end = r_tx == CW'(TILES_X - 1);
  assign o_last    = w_row_end && (r_ty == CW'(TILES_Y - 1));
  assign o_ty      = r_ty;
  assign o_tx      = r_tx;
  // walk tiles row by row; the whole walk wraps to the origin after the last tile
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_ty <= '0;
      r_tx <= '0;
    end else if (i_adv) begin
      r_tx <= w_row_end ? '0 : r_tx + 1'b1;
      r_ty <= o_last ? '0 : (w_row_end ? r_ty + 1'b1 : r_ty);
    end
  end
endmodule

// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks the feature map tile by tile, drives fetch/clear/run of conv and hands results downstream
module conv_tile_sched
  import conv_tile_sched_pkg::*;
#(
  parameter int IMG_H            = 6,
  parameter int IMG_W            = 6,
  parameter int KERNEL_SIZE      = 3,
  parameter int INPUT_TILE_SIZE  = 4,
  parameter int OUTPUT_BIT_WIDTH = 24,
  parameter int TIMEOUT          = 256,
  localparam int OTS     = INPUT_TILE_SIZE - KERNEL_SIZE + 1,
  localparam int OUT_H   = IMG_H - KERNEL_SIZE + 1,
  localparam int OUT_W   = IMG_W - KERNEL_SIZE + 1,
  localparam int TILES_Y = OUT_H / OTS,
  localparam int TILES_X = OUT_W / OTS,
  localparam int CW      = $clog2(max2(IMG_H, IMG_W)),
  localparam int RW      = OTS * OTS * OUTPUT_BIT_WIDTH,
  localparam int TW      = $clog2(TIMEOUT)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          tile_req_valid,
  input  logic          tile_req_ready,
  output logic [CW-1:0] tile_row,
  output logic [CW-1:0] tile_col,
  output logic          conv_reset,
  input  logic          conv_final,
  input  logic [RW-1:0] conv_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic [CW-1:0] res_row,
  output logic [CW-1:0] res_col
);
  if ((OUT_H % OTS) != 0 || (OUT_W % OTS) != 0) begin : g_bad_dims
    $error("conv_tile_sched: output map %0dx%0d does not split into %0d-wide tiles", OUT_H, OUT_W, OTS);
  end
  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tcnt;
  logic          r_err;
  logic [RW-1:0] r_res_data;
  logic [CW-1:0] r_res_row;
  logic [CW-1:0] r_res_col;
  logic [CW-1:0] w_ty;
  logic [CW-1:0] w_tx;
  logic          w_last;
  logic          w_accept;
  logic          w_timeout;
  logic          w_capture;
  conv_tile_sched_coord #(
    .TILES_Y (TILES_Y),
    .TILES_X (TILES_X),
    .CW      (CW)
  ) u_coord (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_accept),
    .i_adv  (r_state == S_ADV),
    .o_ty   (w_ty),
    .o_tx   (w_tx),
    .o_last (w_last)
  );
  assign w_accept       = (r_state == S_IDLE) && start;
  assign w_capture      = (r_state == S_RUN) && conv_final;
  assign w_timeout      = (r_state == S_RUN) && !conv_final && (r_tcnt == TW'(TIMEOUT - 1));
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done           = r_state == S_DONE;
  assign err            = r_err;
  assign tile_req_valid = r_state == S_REQ;
  assign conv_reset     = r_state == S_CLEAR;
  assign res_valid      = r_state == S_EMIT;
  assign tile_row       = CW'(w_ty * OTS);
  assign tile_col       = CW'(w_tx * OTS);
  assign res_data       = r_res_data;
  assign res_row        = r_res_row;
  assign res_col        = r_res_col;
  // next-state: handshakes gate REQ and EMIT, conv completion or timeout leaves RUN
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_REQ : S_IDLE;
      S_REQ:   w_next = tile_req_ready ? S_CLEAR : S_REQ;
      S_CLEAR: w_next = S_RUN;
      S_RUN:   w_next = conv_final ? S_EMIT : (w_timeout ? S_ADV : S_RUN);
      S_EMIT:  w_next = res_ready ? S_ADV : S_EMIT;
      S_ADV:   w_next = w_last ? S_DONE : S_REQ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_next;
  // RUN cycle counter, restarted while conv is being cleared
  always_ff @(posedge clk) begin
    if (reset || r_state == S_CLEAR) r_tcnt <= '0;
    else if (r_state == S_RUN) r_tcnt <= r_tcnt + 1'b1;
  end
  // sticky timeout flag, cleared when a new pass is accepted
  always_ff @(posedge clk) begin
    if (reset || w_accept) r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end
  // result capture on conv completion, tagged with the tile origin
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_data <= '0;
      r_res_row  <= '0;
      r_res_col  <= '0;
    end else if (w_capture) begin
      r_res_data <= conv_out;
      r_res_row  <= tile_row;
      r_res_col  <= tile_col;
    end
  end
endmodule

// File: tb/tb_conv_tile_sched.sv
// tb_conv_tile_sched: directed scenarios with randomized maps, conv latency and handshakes against a conv reference
module tb_conv_tile_sched;
  localparam int OTS = 2;
  localparam int RW  = 96;
  localparam int CW  = 3;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, err, tile_req_valid, conv_reset, res_valid;
  logic          tile_req_ready = 1'b0;
  logic          conv_final = 1'b0;
  logic          res_ready = 1'b0;
  logic [RW-1:0] conv_out = '0;
  logic [CW-1:0] tile_row, tile_col, res_row, res_col;
  logic [RW-1:0] res_data;
  typedef struct {
    int            row;
    int            col;
    logic [RW-1:0] data;
  } exp_t;
  exp_t q[$];
  int   img[3][6][6];
  int   ker[3][3][3];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   done_cnt = 0;
  int   res_cnt = 0;
  int   clr_cnt = 0;
  int   fetch_hold = 0;
  int   res_hold = 0;
  int   lat_fixed = 0;
  bit   never = 1'b0;

  always #5 clk = ~clk;

  conv_tile_sched #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .tile_req_valid (tile_req_valid),
    .tile_req_ready (tile_req_ready),
    .tile_row       (tile_row),
    .tile_col       (tile_col),
    .conv_reset     (conv_reset),
    .conv_final     (conv_final),
    .conv_out       (conv_out),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_row        (res_row),
    .res_col        (res_col)
  );

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] tile_val(input int r, input int c);
    logic [RW-1:0] v;
    int s;
    v = '0;
    for (int i = 0; i < OTS; i++)
      for (int j = 0; j < OTS; j++) begin
        s = 0;
        for (int ch = 0; ch < 3; ch++)
          for (int ki = 0; ki < 3; ki++)
            for (int kj = 0; kj < 3; kj++)
              s += img[ch][r+i+ki][c+j+kj] * ker[ch][ki][kj];
        v[(i*OTS+j)*24 +: 24] = s[23:0];
      end
    return v;
  endfunction

  task automatic fill(input bit rnd);
    for (int ch = 0; ch < 3; ch++) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          img[ch][r][c] = rnd ? int'($urandom_range(0, 255)) : 1;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          ker[ch][r][c] = rnd ? int'($urandom_range(0, 255)) : 1;
    end
  endtask

  task automatic push_expect(input bit ones);
    exp_t e;
    for (int ty = 0; ty < 2; ty++)
      for (int tx = 0; tx < 2; tx++) begin
        e.row = ty * OTS;
        e.col = tx * OTS;
        if (ones) begin
          e.data = '0;
          for (int k = 0; k < 4; k++) e.data[k*24 +: 24] = 24'd27;
        end else e.data = tile_val(e.row, e.col);
        q.push_back(e);
      end
  endtask

  // conv stand-in: cleared by conv_reset, raises final after a latency and holds it until the next clear
  int ccnt = 0;
  int cr = 0;
  int cc = 0;
  always @(negedge clk) begin
    if (reset) begin
      conv_final = 1'b0;
      conv_out   = '0;
      ccnt       = 0;
    end else if (conv_reset) begin
      conv_final = 1'b0;
      conv_out   = '0;
      ccnt       = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 8));
      cr         = int'(tile_row);
      cc         = int'(tile_col);
    end else if (ccnt > 0) begin
      ccnt--;
      if (ccnt == 0 && !never) begin
        conv_final = 1'b1;
        conv_out   = tile_val(cr, cc);
      end
    end
  end

  // fetcher: random or forced accept delay; a pending request must hold its coordinates
  logic [CW-1:0] snap_r, snap_c;
  bit            req_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      tile_req_ready = 1'b0;
      req_prev       = 1'b0;
    end else begin
      if (req_prev) begin
        check("req_held_valid", RW'(tile_req_valid), RW'(1));
        check("req_held_coord", RW'({tile_row, tile_col}), RW'({snap_r, snap_c}));
      end
      if (tile_req_valid) begin
        if (!req_prev) begin
          snap_r = tile_row;
          snap_c = tile_col;
        end
        if (fetch_hold > 0) begin
          fetch_hold--;
          tile_req_ready = 1'b0;
        end else tile_req_ready = ($urandom % 3) != 0;
        req_prev = !tile_req_ready;
      end else begin
        tile_req_ready = 1'($urandom % 2);
        req_prev       = 1'b0;
      end
    end
  end

  // downstream: random or forced backpressure, held results must stay stable, accepted ones are scored
  logic [RW-1:0] snap_d;
  logic [CW-1:0] snap_rr, snap_rc;
  bit            res_prev = 1'b0;
  exp_t          e_pop;
  always @(negedge clk) begin
    if (reset) begin
      res_ready = 1'b0;
      res_prev  = 1'b0;
    end else begin
      if (res_prev) begin
        check("res_held_valid", RW'(res_valid), RW'(1));
        check("res_held_data", res_data, snap_d);
        check("res_held_coord", RW'({res_row, res_col}), RW'({snap_rr, snap_rc}));
      end
      if (res_valid) begin
        if (!res_prev) begin
          snap_d  = res_data;
          snap_rr = res_row;
          snap_rc = res_col;
        end
        if (res_hold > 0) begin
          res_hold--;
          res_ready = 1'b0;
          check("no_req_while_emit", RW'(tile_req_valid), '0);
        end else res_ready = ($urandom % 4) != 0;
        if (res_ready) begin
          res_cnt++;
          n_cmp++;
          assert (q.size() > 0) else begin
            n_mis++;
            $error("FAIL unexpected_result: observed result at (%0d,%0d) expected none", res_row, res_col);
          end
          if (q.size() > 0) begin
            e_pop = q.pop_front();
            check("res_row", RW'(res_row), RW'(e_pop.row));
            check("res_col", RW'(res_col), RW'(e_pop.col));
            check("res_data", res_data, e_pop.data);
          end
        end
        res_prev = !res_ready;
      end else begin
        res_ready = 1'($urandom % 2);
        res_prev  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (conv_reset) clr_cnt++;
  end

  task automatic check_zero(input string tag);
    check(tag, RW'({busy, done, err, tile_req_valid, conv_reset, res_valid, tile_row, tile_col, res_row, res_col}), '0);
    check({tag, "_data"}, res_data, '0);
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit spam, input bit exp_err, input int exp_res, input int d0, input int r0);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else if (spam) start = busy ? 1'($urandom % 2) : 1'b0;
    end
    check("pass_done_seen", RW'(seen), RW'(1));
    @(negedge clk);
    check("pass_idle", RW'(busy), '0);
    check("pass_done_count", RW'(done_cnt - d0), RW'(1));
    check("pass_result_count", RW'(res_cnt - r0), RW'(exp_res));
    check("pass_err", RW'(err), RW'(exp_err));
    check("pass_all_scored", RW'(q.size()), '0);
  endtask

  int  d0, r0, c0, n, k;
  bit  found;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    // 1: all-ones map and kernel, every element 27
    fill(1'b0);
    push_expect(1'b1);
    d0 = done_cnt; r0 = res_cnt;
    kick();
    wait_done(1'b0, 1'b0, 4, d0, r0);
    // 2: fetcher stalls the first request
    fill(1'b1);
    push_expect(1'b0);
    fetch_hold = 12;
    d0 = done_cnt; r0 = res_cnt;
    kick();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_req_valid", RW'(tile_req_valid), RW'(1));
      check("stall_no_clear", RW'(conv_reset), '0);
      check("stall_coord", RW'({tile_row, tile_col}), '0);
    end
    wait_done(1'b0, 1'b0, 4, d0, r0);
    // 3: downstream backpressure for 20 cycles on the first result
    fill(1'b1);
    push_expect(1'b0);
    res_hold = 20;
    d0 = done_cnt; r0 = res_cnt;
    kick();
    wait_done(1'b0, 1'b0, 4, d0, r0);
    // 4: conv never finishes, each tile times out after 16 RUN cycles
    never = 1'b1;
    d0 = done_cnt; r0 = res_cnt; c0 = clr_cnt;
    kick();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (conv_reset) found = 1'b1;
      else @(negedge clk);
    end
    check("tmo_clear_seen", RW'(found), RW'(1));
    check("tmo_err_before", RW'(err), '0);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      n++;
      if (n == 16) check("tmo_err_last_run", RW'(err), '0);
      if (tile_req_valid) found = 1'b1;
    end
    check("tmo_gap_to_next_req", RW'(n), RW'(18));
    check("tmo_err_after", RW'(err), RW'(1));
    wait_done(1'b0, 1'b1, 0, d0, r0);
    check("tmo_tiles_cleared", RW'(clr_cnt - c0), RW'(4));
    never = 1'b0;
    // 4b: completion on the final allowed RUN cycle wins, and the new start clears err
    fill(1'b1);
    push_expect(1'b0);
    lat_fixed = 16;
    d0 = done_cnt; r0 = res_cnt;
    kick();
    check("err_cleared_by_start", RW'(err), '0);
    wait_done(1'b0, 1'b0, 4, d0, r0);
    // 5: reset during RUN of the second tile
    fill(1'b1);
    push_expect(1'b0);
    lat_fixed = 12;
    d0 = done_cnt;
    kick();
    k = 0;
    for (int i = 0; i < 300 && k < 2; i++) begin
      @(negedge clk);
      if (conv_reset) k++;
    end
    check("abort_second_clear", RW'(k), RW'(2));
    check("abort_tile2_coord", RW'({tile_row, tile_col}), RW'({3'd0, 3'd2}));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("abort_reset");
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    check("abort_no_done", RW'(done_cnt - d0), '0);
    lat_fixed = 0;
    push_expect(1'b0);
    d0 = done_cnt; r0 = res_cnt;
    kick();
    check("restart_coord", RW'({tile_row, tile_col}), '0);
    check("restart_err", RW'(err), '0);
    wait_done(1'b0, 1'b0, 4, d0, r0);
    // 6: start spammed while busy
    fill(1'b1);
    push_expect(1'b0);
    d0 = done_cnt; r0 = res_cnt;
    kick();
    wait_done(1'b1, 1'b0, 4, d0, r0);
    repeat (3) @(negedge clk);
    check("spam_stays_idle", RW'(busy), '0);
    check("spam_single_done", RW'(done_cnt - d0), RW'(1));
    // 7: random passes
    for (int p = 0; p < 3; p++) begin
      fill(1'b1);
      push_expect(1'b0);
      d0 = done_cnt; r0 = res_cnt;
      kick();
      wait_done(1'b0, 1'b0, 4, d0, r0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end
endmodule
